// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register: holds the decoded operand bundle for operand select/ALU.
// Optional skid buffer (ID_EX_SKID_EN) gives a fully registered id_ready; default is single-entry.
module id_ex_stage #(
    parameter int XLEN = 64,
    parameter int PC_W = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_reg_data0,
    input  logic [XLEN-1:0] id_reg_data1,
    input  logic            id_op0_sel,
    input  logic            id_op1_sel,
    input  logic [PC_W-1:0] id_pc,
    input  logic [XLEN-1:0] id_sext_imm,
    input  logic            id_is_cinstr,
    input  logic [XLEN-1:0] id_cimm,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_reg_data0,
    output logic [XLEN-1:0] ex_reg_data1,
    output logic            ex_op0_sel,
    output logic            ex_op1_sel,
    output logic [PC_W-1:0] ex_pc,
    output logic [XLEN-1:0] ex_sext_imm,
    output logic            ex_is_cinstr,
    output logic [XLEN-1:0] ex_cimm,
    output logic [15:0]     stall_cnt
);

    typedef struct packed {
        logic [XLEN-1:0] reg_data0;
        logic [XLEN-1:0] reg_data1;
        logic            op0_sel;
        logic            op1_sel;
        logic [PC_W-1:0] pc;
        logic [XLEN-1:0] sext_imm;
        logic            is_cinstr;
        logic [XLEN-1:0] cimm;
    } bundle_t;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;

    logic [1:0]  state_q, state_d;
    bundle_t     main_q, main_d;
    bundle_t     id_bundle;
    logic        in_xfer, out_xfer;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    assign id_bundle = '{
        reg_data0: id_reg_data0,
        reg_data1: id_reg_data1,
        op0_sel:   id_op0_sel,
        op1_sel:   id_op1_sel,
        pc:        id_pc,
        sext_imm:  id_sext_imm,
        is_cinstr: id_is_cinstr,
        cimm:      id_cimm
    };

    assign ex_valid = (state_q != ST_EMPTY);
    assign in_xfer  = id_valid && id_ready;
    assign out_xfer = ex_valid && ex_ready;

`ifdef ID_EX_SKID_EN
    localparam logic [1:0] ST_SKID = 2'd2;

    bundle_t skid_q, skid_d;
    logic    id_ready_q;

    // Registered ready; only reset gates it so the first post-reset cycle can accept.
    assign id_ready = id_ready_q && !rst;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_d = ST_FULL;
                    main_d  = id_bundle;
                end
            end
            ST_FULL: begin
                if (in_xfer && out_xfer) begin
                    main_d = id_bundle;
                end else if (in_xfer) begin
                    state_d = ST_SKID;
                    skid_d  = id_bundle;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (out_xfer) begin
                    state_d = ST_FULL;
                    main_d  = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            id_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            id_ready_q <= (state_d != ST_SKID);
        end
    end
`else
    // Combinational ready lets a full stage refill in the cycle execute drains it.
    assign id_ready = !rst && (!ex_valid || ex_ready);

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else if (in_xfer) begin
            state_d = ST_FULL;
            main_d  = id_bundle;
        end else if (out_xfer) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end
`endif

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (ex_valid && !ex_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign ex_reg_data0 = main_q.reg_data0;
    assign ex_reg_data1 = main_q.reg_data1;
    assign ex_op0_sel   = main_q.op0_sel;
    assign ex_op1_sel   = main_q.op1_sel;
    assign ex_pc        = main_q.pc;
    assign ex_sext_imm  = main_q.sext_imm;
    assign ex_is_cinstr = main_q.is_cinstr;
    assign ex_cimm      = main_q.cimm;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: per-cycle vector table plus a stall-counter saturation run.
module tb_id_ex_stage;

`ifdef ID_EX_SKID_EN
    localparam bit S = 1'b1;
`else
    localparam bit S = 1'b0;
`endif
    localparam int BW = 323;

    logic        clk, rst, flush, id_valid, id_ready;
    logic [63:0] id_reg_data0, id_reg_data1, id_pc, id_sext_imm, id_cimm;
    logic        id_op0_sel, id_op1_sel, id_is_cinstr;
    logic        ex_valid, ex_ready;
    logic [63:0] ex_reg_data0, ex_reg_data1, ex_pc, ex_sext_imm, ex_cimm;
    logic        ex_op0_sel, ex_op1_sel, ex_is_cinstr;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    id_ex_stage #(.XLEN(64), .PC_W(64)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_reg_data0(id_reg_data0), .id_reg_data1(id_reg_data1),
        .id_op0_sel(id_op0_sel), .id_op1_sel(id_op1_sel),
        .id_pc(id_pc), .id_sext_imm(id_sext_imm),
        .id_is_cinstr(id_is_cinstr), .id_cimm(id_cimm),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_reg_data0(ex_reg_data0), .ex_reg_data1(ex_reg_data1),
        .ex_op0_sel(ex_op0_sel), .ex_op1_sel(ex_op1_sel),
        .ex_pc(ex_pc), .ex_sext_imm(ex_sext_imm),
        .ex_is_cinstr(ex_is_cinstr), .ex_cimm(ex_cimm),
        .stall_cnt(stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          rst;
        bit          flush;
        bit          vld;
        logic [63:0] pc;
        bit          rdy;
        bit          exp_vld;
        logic [63:0] exp_pc;
        bit          exp_rdy;
        logic [15:0] exp_cnt;
        logic [1:0]  chk;   // 0: no data check, 1: bundle of exp_pc, 2: all zero
    } vec_t;

    vec_t tbl[$];

    // Bundle contents derived from the pc so every field differs between bundles.
    function automatic logic [BW-1:0] mk(input logic [63:0] pc);
        mk = {{32'hD0D0_D0D0, pc[31:0]}, {pc[31:0], 32'h1111_1111}, pc[2], pc[3], pc,
              64'hFFFF_FFFF_FFFF_FFF0 ^ {48'd0, pc[7:0], 8'd0}, pc[4],
              {48'd0, pc[15:0]} ^ 64'h5};
    endfunction

    function automatic logic [BW-1:0] ex_bus();
        ex_bus = {ex_reg_data0, ex_reg_data1, ex_op0_sel, ex_op1_sel, ex_pc,
                  ex_sext_imm, ex_is_cinstr, ex_cimm};
    endfunction

    task automatic drive(input bit r, input bit f, input bit v, input logic [63:0] pc, input bit rd);
        logic [BW-1:0] b;
        b = mk(pc);
        rst = r; flush = f; id_valid = v; ex_ready = rd;
        {id_reg_data0, id_reg_data1, id_op0_sel, id_op1_sel, id_pc,
         id_sext_imm, id_is_cinstr, id_cimm} = b;
    endtask

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input bit r, input bit f, input bit v, input logic [63:0] pc, input bit rd,
                       input bit ev, input logic [63:0] ep, input bit er, input logic [15:0] ec,
                       input logic [1:0] ck);
        vec_t t;
        t.rst = r; t.flush = f; t.vld = v; t.pc = pc; t.rdy = rd;
        t.exp_vld = ev; t.exp_pc = ep; t.exp_rdy = er; t.exp_cnt = ec; t.chk = ck;
        tbl.push_back(t);
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b1, 64'h0F00, 1'b1);

        // rst flush vld pc rdy | ex_valid ex_pc id_ready stall_cnt check  (expected before the edge)
        repeat (3) add(1'b1, 1'b0, 1'b1, 64'h0F00, 1'b1,  1'b0, 64'h0, 1'b0, 16'd0, 2'd2);
        add(1'b0, 1'b0, 1'b0, 64'h0,    1'b1,  1'b0, 64'h0,    1'b1, 16'd0, 2'd2);
        // streaming
        add(1'b0, 1'b0, 1'b1, 64'h1000, 1'b1,  1'b0, 64'h0,    1'b1, 16'd0, 2'd2);
        add(1'b0, 1'b0, 1'b1, 64'h1004, 1'b1,  1'b1, 64'h1000, 1'b1, 16'd0, 2'd1);
        add(1'b0, 1'b0, 1'b1, 64'h1008, 1'b1,  1'b1, 64'h1004, 1'b1, 16'd0, 2'd1);
        add(1'b0, 1'b0, 1'b0, 64'h0,    1'b1,  1'b1, 64'h1008, 1'b1, 16'd0, 2'd1);
        add(1'b0, 1'b0, 1'b0, 64'h0,    1'b1,  1'b0, 64'h0,    1'b1, 16'd0, 2'd0);
        // back-pressure: skid absorbs 0x2004 on the first stall cycle
        add(1'b0, 1'b0, 1'b1, 64'h2000, 1'b1,  1'b0, 64'h0,    1'b1, 16'd0, 2'd0);
        add(1'b0, 1'b0, 1'b1, 64'h2004, 1'b0,  1'b1, 64'h2000, S,    16'd0, 2'd1);
        add(1'b0, 1'b0, !S,   64'h2004, 1'b0,  1'b1, 64'h2000, 1'b0, 16'd1, 2'd1);
        add(1'b0, 1'b0, !S,   64'h2004, 1'b0,  1'b1, 64'h2000, 1'b0, 16'd2, 2'd1);
        add(1'b0, 1'b0, !S,   64'h2004, 1'b0,  1'b1, 64'h2000, 1'b0, 16'd3, 2'd1);
        add(1'b0, 1'b0, !S,   64'h2004, 1'b1,  1'b1, 64'h2000, !S,   16'd4, 2'd1);
        add(1'b0, 1'b0, 1'b0, 64'h0,    1'b1,  1'b1, 64'h2004, 1'b1, 16'd4, 2'd1);
        add(1'b0, 1'b0, 1'b0, 64'h0,    1'b1,  1'b0, 64'h0,    1'b1, 16'd4, 2'd0);
        // flush while full with an input offered
        add(1'b0, 1'b0, 1'b1, 64'h3000, 1'b0,  1'b0, 64'h0,    1'b1, 16'd4, 2'd0);
        add(1'b0, 1'b1, 1'b1, 64'h3004, 1'b0,  1'b1, 64'h3000, S,    16'd4, 2'd1);
        add(1'b0, 1'b0, 1'b0, 64'h0,    1'b0,  1'b0, 64'h0,    1'b1, 16'd5, 2'd0);
        add(1'b0, 1'b0, 1'b0, 64'h0,    1'b1,  1'b0, 64'h0,    1'b1, 16'd5, 2'd0);
        // simultaneous input and output transfer
        add(1'b0, 1'b0, 1'b1, 64'h4000, 1'b1,  1'b0, 64'h0,    1'b1, 16'd5, 2'd0);
        add(1'b0, 1'b0, 1'b1, 64'h4004, 1'b1,  1'b1, 64'h4000, 1'b1, 16'd5, 2'd1);
        add(1'b0, 1'b0, 1'b0, 64'h0,    1'b1,  1'b1, 64'h4004, 1'b1, 16'd5, 2'd1);
        add(1'b0, 1'b0, 1'b0, 64'h0,    1'b1,  1'b0, 64'h0,    1'b1, 16'd5, 2'd0);
        // flush coinciding with an output transfer (skid holds 0x5004)
        add(1'b0, 1'b0, 1'b1, 64'h5000, 1'b1,  1'b0, 64'h0,    1'b1, 16'd5, 2'd0);
        add(1'b0, 1'b0, 1'b1, 64'h5004, 1'b0,  1'b1, 64'h5000, S,    16'd5, 2'd1);
        add(1'b0, 1'b1, !S,   64'h5004, 1'b1,  1'b1, 64'h5000, !S,   16'd6, 2'd1);
        add(1'b0, 1'b0, 1'b0, 64'h0,    1'b1,  1'b0, 64'h0,    1'b1, 16'd6, 2'd0);
        // reset beats flush and clears the counter
        add(1'b1, 1'b1, 1'b0, 64'h0,    1'b1,  1'b0, 64'h0,    1'b0, 16'd6, 2'd0);
        add(1'b0, 1'b0, 1'b0, 64'h0,    1'b1,  1'b0, 64'h0,    1'b1, 16'd0, 2'd2);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].flush, tbl[i].vld, tbl[i].pc, tbl[i].rdy);
            #1;
            chk($sformatf("row%0d ex_valid", i), BW'(ex_valid), BW'(tbl[i].exp_vld));
            chk($sformatf("row%0d id_ready", i), BW'(id_ready), BW'(tbl[i].exp_rdy));
            chk($sformatf("row%0d stall_cnt", i), BW'(stall_cnt), BW'(tbl[i].exp_cnt));
            if (tbl[i].chk == 2'd1) begin
                chk($sformatf("row%0d ex_pc", i), BW'(ex_pc), BW'(tbl[i].exp_pc));
                chk($sformatf("row%0d bundle", i), ex_bus(), mk(tbl[i].exp_pc));
            end else if (tbl[i].chk == 2'd2) begin
                chk($sformatf("row%0d zero bundle", i), ex_bus(), '0);
            end
        end

        // saturation: one bundle held under a long stall
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 64'h6000, 1'b0);
        #1;
        chk("sat accept ready", BW'(id_ready), BW'(1'b1));
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        repeat (65534) @(posedge clk);
        @(negedge clk);
        chk("sat cnt 0xFFFE", BW'(stall_cnt), BW'(16'hFFFE));
        @(negedge clk);
        chk("sat cnt 0xFFFF", BW'(stall_cnt), BW'(16'hFFFF));
        repeat (4500) @(posedge clk);
        @(negedge clk);
        chk("sat no wrap", BW'(stall_cnt), BW'(16'hFFFF));
        chk("sat held bundle", ex_bus(), mk(64'h6000));
        chk("sat ex_valid", BW'(ex_valid), BW'(1'b1));
        ex_ready = 1'b1;
        @(negedge clk);
        chk("sat drained", BW'(ex_valid), BW'(1'b0));
        chk("sat cnt after drain", BW'(stall_cnt), BW'(16'hFFFF));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
